// File: rtl/bcd_gate_controller.sv
`default_nettype none
// ============================================================================
// Module   : bcd_gate_controller
// Brief    : Gated measurement sequencer for an N-digit BCD event counter.
// Revision : 1.0
// ============================================================================
module bcd_gate_controller #(
    parameter int NDIGIT     = 4,
    parameter int GATE_TICKS = 1000,
    parameter int CONTINUOUS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  tick,
    input  logic                  evt,
    input  logic [4*NDIGIT-1:0]   cnt_bcd,
    input  logic                  cnt_ovf,
    output logic                  cnt_clr,
    output logic                  cnt_en,
    output logic                  busy,
    output logic                  done,
    output logic [4*NDIGIT-1:0]   result,
    output logic                  result_ovf
);

    localparam int c_GW = $clog2(GATE_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ARM   = 3'd2,
        S_GATE  = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_evt_q;
    logic [c_GW-1:0]   r_gate_cnt;
    logic              r_ovf_sticky;
    logic              w_evt_rise;
    logic              w_last_tick;

    assign w_evt_rise  = evt & ~r_evt_q;
    assign w_last_tick = tick && (r_gate_cnt == c_GW'(1));

    always_comb begin
        w_state_nxt = r_state;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !abort) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_clr     = 1'b1;
                w_state_nxt = abort ? S_IDLE : S_ARM;
            end
            S_ARM: begin
                if (abort)     w_state_nxt = S_IDLE;
                else if (tick) w_state_nxt = S_GATE;
            end
            S_GATE: begin
                // The rise coinciding with the closing tick is still counted.
                cnt_en = w_evt_rise;
                if (abort)            w_state_nxt = S_IDLE;
                else if (w_last_tick) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                w_state_nxt = abort ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (!abort && (CONTINUOUS != 0 || start)) w_state_nxt = S_CLEAR;
                else                                      w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_evt_q      <= 1'b0;
            r_gate_cnt   <= '0;
            r_ovf_sticky <= 1'b0;
            result       <= '0;
            result_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_evt_q <= evt;
            case (r_state)
                S_CLEAR: begin
                    r_gate_cnt   <= c_GW'(GATE_TICKS);
                    r_ovf_sticky <= 1'b0;
                end
                S_GATE: begin
                    if (tick)             r_gate_cnt   <= r_gate_cnt - c_GW'(1);
                    if (cnt_en && cnt_ovf) r_ovf_sticky <= 1'b1;
                end
                S_FLUSH: begin
                    // An abort here discards the measurement.
                    if (!abort) begin
                        result     <= cnt_bcd;
                        result_ovf <= r_ovf_sticky;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
